systolic_skew_loader: RTL and testbench

//  Operand loader for the systolic array's row edge: accepts a serial element

---
 rtl/systolic_skew_loader.sv | 105 ++++++++++
 tb/tb_systolic_skew_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_loader.sv
// Operand loader for a systolic array's west edge: fills one H x D tile row-major
// from a serial stream, then drains it as diagonally skewed lane vectors.
module systolic_skew_loader #(
   parameter int width_p        = 8,
   parameter int array_height_p = 2,
   parameter int depth_p        = 2
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic                              en_i,
   input  logic                              flush_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   input  logic [width_p-1:0]                data_i,
   output logic                              valid_o,
   input  logic                              yumi_i,
   output logic [array_height_p*width_p-1:0] data_o,
   output logic [array_height_p-1:0]         lane_v_o,
   output logic                              last_o
);

   localparam int n_lp      = array_height_p * depth_p;
   localparam int steps_lp  = depth_p + array_height_p - 1;
   localparam int idx_w_lp  = (n_lp > 1) ? $clog2(n_lp) : 1;
   localparam int step_w_lp = (steps_lp > 1) ? $clog2(steps_lp) : 1;

   typedef enum logic {FILL, DRAIN} state_e;

   state_e                 state_q, state_d;
   logic [idx_w_lp-1:0]    idx_q;
   logic [step_w_lp-1:0]   step_q;
   logic [width_p-1:0]     mem_q [n_lp];

   logic accept, take, last_idx, last_step;

   assign ready_o   = (state_q == FILL) && en_i;
   assign valid_o   = (state_q == DRAIN) && en_i;
   assign accept    = ready_o && valid_i;
   assign take      = valid_o && yumi_i;
   assign last_idx  = (idx_q == idx_w_lp'(n_lp - 1));
   assign last_step = (step_q == step_w_lp'(steps_lp - 1));
   assign last_o    = valid_o && last_step;

   // A flush only closes a tile that holds at least one element.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: begin
            if (accept && last_idx)
               state_d = DRAIN;
            else if (en_i && flush_i && (accept || idx_q != '0))
               state_d = DRAIN;
         end
         DRAIN: begin
            if (take && last_step)
               state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   // NOTE: the tile buffer is reset and cleared explicitly so a flushed or
   // reset-aborted tile can never leak stale elements into the next one.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= FILL;
         idx_q   <= '0;
         step_q  <= '0;
         for (int i = 0; i < n_lp; i++) mem_q[i] <= '0;
      end else if (en_i) begin
         state_q <= state_d;
         if (accept)
            idx_q <= idx_q + idx_w_lp'(1);
         if (take) begin
            if (last_step) begin
               step_q <= '0;
               idx_q  <= '0;
            end else begin
               step_q <= step_q + step_w_lp'(1);
            end
         end
         for (int i = 0; i < n_lp; i++) begin
            if (take && last_step)
               mem_q[i] <= '0;
            else if (accept && idx_q == idx_w_lp'(i))
               mem_q[i] <= data_i;
         end
      end
   end

   // Lane r shows column (step - r) of row r; outputs stay zero outside DRAIN.
   always_comb begin
      data_o   = '0;
      lane_v_o = '0;
      for (int r = 0; r < array_height_p; r++) begin
         int k;
         k = int'(step_q) - r;
         if (state_q == DRAIN && k >= 0 && k < depth_p) begin
            data_o[r*width_p +: width_p] = mem_q[r*depth_p + k];
            lane_v_o[r]                  = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_systolic_skew_loader.sv
// Self-checking bench for systolic_skew_loader: tile table + expected-vector
// scoreboard on a 2x2 instance, plus a generic model check on a 4x3 instance.
module tb_systolic_skew_loader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, en, flush, valid_in, yumi;
   logic [7:0]  data_in;
   logic        ready, valid_out, last;
   logic [15:0] data_out;
   logic [1:0]  lane_v;

   logic        valid2_in, yumi2, ready2, valid2_out, last2;
   logic [7:0]  data2_in;
   logic [31:0] data2_out;
   logic [3:0]  lane2_v;

   systolic_skew_loader #(.width_p(8), .array_height_p(2), .depth_p(2)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .flush_i(flush),
      .valid_i(valid_in), .ready_o(ready), .data_i(data_in),
      .valid_o(valid_out), .yumi_i(yumi), .data_o(data_out),
      .lane_v_o(lane_v), .last_o(last)
   );

   systolic_skew_loader #(.width_p(8), .array_height_p(4), .depth_p(3)) dut2 (
      .clk_i(clk), .reset_n_i(reset_n), .en_i(1'b1), .flush_i(1'b0),
      .valid_i(valid2_in), .ready_o(ready2), .data_i(data2_in),
      .valid_o(valid2_out), .yumi_i(yumi2), .data_o(data2_out),
      .lane_v_o(lane2_v), .last_o(last2)
   );

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  v;
      logic        last;
   } exp_t;

   typedef struct packed {
      logic [2:0]        n;
      logic              flush;
      logic [3:0][7:0]   e;
      logic [2:0][15:0]  d;
      logic [2:0][1:0]   v;
   } tile_t;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  v;
      logic        last;
   } exp2_t;

   exp_t  sb[$];
   exp2_t sb2[$];
   tile_t tiles[4];
   int    checks = 0;
   int    errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Stream one tile; optionally hold en low for gap_n cycles before element gap_at.
   task automatic feed(input int t, input int gap_at, input int gap_n);
      for (int i = 0; i < int'(tiles[t].n); i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_n; g++) begin
               @(negedge clk); en = 1'b0; valid_in = 1'b1; data_in = 8'hEE; #1;
               check("fill_gap_ready", {31'd0, ready}, 32'd0);
               check("fill_gap_valid", {31'd0, valid_out}, 32'd0);
            end
         end
         @(negedge clk); en = 1'b1; valid_in = 1'b1; data_in = tiles[t].e[i]; #1;
         check("fill_ready", {31'd0, ready}, 32'd1);
      end
      for (int s = 0; s < 3; s++)
         sb.push_back('{d: tiles[t].d[s], v: tiles[t].v[s], last: (s == 2)});
      @(negedge clk); valid_in = 1'b0; en = 1'b1;
      if (tiles[t].flush) begin
         flush = 1'b1; #1;
         check("flush_cycle_valid", {31'd0, valid_out}, 32'd0);
         @(negedge clk); flush = 1'b0;
      end
      #1;
      check("latency_valid", {31'd0, valid_out}, 32'd1);
      check("drain_ready_low", {31'd0, ready}, 32'd0);
   endtask

   // Consume stop_after steps; at step stall_at, hold yumi (or en if stall_en) low.
   task automatic drain(input int stall_at, input int stall_n, input bit stall_en, input int stop_after);
      int step = 0;
      int budget = 0;
      while (step < stop_after && budget < 40) begin
         @(negedge clk); budget++;
         if (step == stall_at && stall_n > 0) begin
            stall_n--;
            en   = !stall_en;
            yumi = stall_en;
            #1;
            if (stall_en) begin
               check("drain_gap_valid", {31'd0, valid_out}, 32'd0);
               check("drain_gap_ready", {31'd0, ready}, 32'd0);
            end else if (sb.size() > 0) begin
               check("stall_hold_data", {16'd0, data_out}, {16'd0, sb[0].d});
               check("stall_hold_v", {30'd0, lane_v}, {30'd0, sb[0].v});
            end
         end else begin
            en = 1'b1; yumi = 1'b1; #1;
            if (valid_out) begin
               if (sb.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL scoreboard_empty actual=vector expected=none");
               end else begin
                  exp_t x;
                  x = sb.pop_front();
                  check("step_data", {16'd0, data_out}, {16'd0, x.d});
                  check("step_lane_v", {30'd0, lane_v}, {30'd0, x.v});
                  check("step_last", {31'd0, last}, {31'd0, x.last});
               end
               step++;
            end
         end
      end
      if (step < stop_after) begin
         errors++; checks++;
         $display("FAIL drain_timeout actual=%0d expected=%0d", step, stop_after);
      end
      @(negedge clk); yumi = 1'b0; en = 1'b1; #1;
   endtask

   initial begin
      tiles[0] = '{n: 3'd4, flush: 1'b0, e: {8'd4, 8'd3, 8'd2, 8'd1},
                   d: {16'h0400, 16'h0302, 16'h0001}, v: {2'b10, 2'b11, 2'b01}};
      tiles[1] = '{n: 3'd3, flush: 1'b1, e: {8'd0, 8'd3, 8'd2, 8'd1},
                   d: {16'h0000, 16'h0302, 16'h0001}, v: {2'b10, 2'b11, 2'b01}};
      tiles[2] = '{n: 3'd4, flush: 1'b0, e: {8'd8, 8'd7, 8'd6, 8'd5},
                   d: {16'h0800, 16'h0706, 16'h0005}, v: {2'b10, 2'b11, 2'b01}};
      tiles[3] = '{n: 3'd4, flush: 1'b0, e: {8'd9, 8'd9, 8'd9, 8'd9},
                   d: {16'h0900, 16'h0909, 16'h0009}, v: {2'b10, 2'b11, 2'b01}};

      reset_n = 1'b0; en = 1'b1; flush = 1'b0; valid_in = 1'b0; yumi = 1'b0; data_in = '0;
      valid2_in = 1'b0; yumi2 = 1'b0; data2_in = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_valid", {31'd0, valid_out}, 32'd0);
      check("reset_data", {16'd0, data_out}, 32'd0);
      check("reset_lane_v", {30'd0, lane_v}, 32'd0);
      check("reset_ready", {31'd0, ready}, 32'd1);
      check("reset_last", {31'd0, last}, 32'd0);
      @(negedge clk); reset_n = 1'b1;

      // Flush with an empty tile must be ignored.
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0; #1;
      check("empty_flush_valid", {31'd0, valid_out}, 32'd0);
      check("empty_flush_ready", {31'd0, ready}, 32'd1);

      feed(0, -1, 0); drain(-1, 0, 1'b0, 3);
      check("after_drain_ready", {31'd0, ready}, 32'd1);
      check("after_drain_valid", {31'd0, valid_out}, 32'd0);

      feed(0, -1, 0); drain(1, 3, 1'b0, 3);
      feed(1, -1, 0); drain(-1, 0, 1'b0, 3);
      feed(2, -1, 0); drain(-1, 0, 1'b0, 3);
      feed(0, 2, 4);  drain(1, 4, 1'b1, 3);

      // Reset while parked at step 1 of a drain.
      feed(0, -1, 0); drain(-1, 0, 1'b0, 1);
      check("pre_reset_data", {16'd0, data_out}, 32'h0302);
      reset_n = 1'b0; #1;
      check("midreset_valid", {31'd0, valid_out}, 32'd0);
      check("midreset_data", {16'd0, data_out}, 32'd0);
      check("midreset_lane_v", {30'd0, lane_v}, 32'd0);
      check("midreset_ready", {31'd0, ready}, 32'd1);
      sb.delete();
      @(negedge clk); reset_n = 1'b1;
      feed(3, -1, 0); drain(-1, 0, 1'b0, 3);

      // 4x3 instance: stream 1..12, compare against a generic skew model.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); valid2_in = 1'b1; data2_in = 8'(i + 1); #1;
         check("h4_fill_ready", {31'd0, ready2}, 32'd1);
      end
      for (int s = 0; s < 6; s++) begin
         exp2_t x;
         x = '0;
         for (int r = 0; r < 4; r++) begin
            int k;
            k = s - r;
            if (k >= 0 && k < 3) begin
               x.d[r*8 +: 8] = 8'(r*3 + k + 1);
               x.v[r] = 1'b1;
            end
         end
         x.last = (s == 5);
         sb2.push_back(x);
      end
      @(negedge clk); valid2_in = 1'b0; yumi2 = 1'b1; #1;
      for (int s = 0; s < 6; s++) begin
         exp2_t x;
         x = sb2.pop_front();
         check("h4_valid", {31'd0, valid2_out}, 32'd1);
         check("h4_data", data2_out, x.d);
         check("h4_lane_v", {28'd0, lane2_v}, {28'd0, x.v});
         check("h4_last", {31'd0, last2}, {31'd0, x.last});
         if (s == 3) begin
            check("h4_s3_data", data2_out, 32'h0A080600);
            check("h4_s3_lane_v", {28'd0, lane2_v}, 32'hE);
         end
         @(negedge clk); #1;
      end
      yumi2 = 1'b0; #1;
      check("h4_done_ready", {31'd0, ready2}, 32'd1);
      check("h4_done_valid", {31'd0, valid2_out}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
